reaction_timer_core: RTL and testbench
======================================

REACTION_TIMER_CORE -- requirements
Module: reaction_timer_core

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning the input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1000, meaning the timing tick rate; DIV = CLK_HZ/TICK_HZ, and DIV SHALL be at least 2.
REQ-003 SHALL have parameter LFSR_W, default 11, meaning the random-delay LFSR width, legal range 4..16.
REQ-004 SHALL have parameter MIN_DELAY, default 500, meaning the fixed delay offset in ticks.
REQ-005 SHALL have parameter NDIG, default 4, meaning the number of BCD digits of the reaction time.
REQ-006 SHALL have parameter NP, default 2, meaning the number of player react inputs, legal range 1..8.
REQ-007 SHALL have port MAX10_CLK1_50, input, width 1, the single clock; all logic is on its rising edge.
REQ-008 SHALL have port reset, input, width 1; reset is asynchronous and active-high.
REQ-009 SHALL have port start, input, width 1, a synchronous level; only its rising edge acts.
REQ-010 SHALL have port react, input, width NP, synchronous levels, one bit per player.
REQ-011 SHALL have port state, output, width 3, the current FSM state encoding.
REQ-012 SHALL have port led_on, output, width 1, the "react now" lamp.
REQ-013 SHALL have port delay_ticks, output, width LFSR_W+10, the delay captured for the current round.
REQ-014 SHALL have port time_bcd, output, width 4*NDIG, the reaction time; digit 0 is in the LSBs.
REQ-015 SHALL have port best_bcd, output, width 4*NDIG, the best valid time since reset.
REQ-016 SHALL have port winner, output, width NP, one-hot or multi-hot player flags.
REQ-017 SHALL have ports false_start and timeout, outputs, width 1 each, the round outcome flags.

Function
REQ-018 SHALL implement FSM states IDLE=000, WAIT=001, GO=010, DONE=011, FAULT=100; encodings 101..111 SHALL recover to IDLE on the next clock.
REQ-019 SHALL register start once per clock and detect a rising edge as start=1 while the registered value is 0.
REQ-020 SHALL clock a maximal-length Fibonacci LFSR every cycle in every state; it SHALL never enter the all-zero state.
REQ-021 On a start edge in IDLE, DONE or FAULT, SHALL capture delay_ticks = MIN_DELAY + LFSR value (zero-extended), clear time_bcd, winner, false_start and timeout, set led_on=0, and enter WAIT.
REQ-022 SHALL clear the prescaler to 0 on every entry to WAIT or GO, then count 0..DIV-1; tick is a one-cycle pulse on the cycle the count equals DIV-1.
REQ-023 In WAIT, SHALL decrement an internal copy of delay_ticks on each tick; on the tick where that copy is 1 (or on the first tick if the copy is 0), SHALL enter GO with led_on=1 on the following cycle.
REQ-024 In WAIT, if any react bit is 1, SHALL enter FAULT next cycle with false_start=1, winner=react, and led_on=0; react SHALL take priority over a coincident transition to GO.
REQ-025 In GO, SHALL increment time_bcd on each tick as an NDIG-digit decimal counter; each digit wraps 9->0 with carry, and no digit ever holds 10..15.
REQ-026 In GO, if any react bit is 1, SHALL enter DONE next cycle with winner = all react bits asserted that cycle (ties report multiple bits) and time_bcd frozen; a coincident tick SHALL NOT increment.
REQ-027 In GO, on a tick while time_bcd is all 9s, SHALL enter DONE with timeout=1, winner=0, and time_bcd held at all 9s; react on the same cycle SHALL take priority.
REQ-028 On the DONE entry caused by react, SHALL load best_bcd=time_bcd when time_bcd < best_bcd (unsigned compare on the packed BCD); timeout and FAULT SHALL never update best_bcd.
REQ-029 led_on SHALL be 1 only in GO and SHALL drop to 0 on DONE entry.
REQ-030 In DONE and FAULT, all outputs SHALL hold until a start edge; a start edge in WAIT or GO SHALL be ignored.
REQ-031 react SHALL be ignored in IDLE, DONE and FAULT.

Reset
REQ-032 On reset=1, SHALL immediately set state=IDLE, led_on=0, delay_ticks=0, time_bcd=0, winner=0, false_start=0, timeout=0, prescaler=0, best_bcd=all 9s, LFSR=all ones, and the start register=0, regardless of the current state (including mid-WAIT or mid-GO).
REQ-033 After reset deasserts, SHALL take no action until the first start rising edge; a start held high through reset release SHALL NOT count as an edge.

Verification
REQ-034 With CLK_HZ=4000, TICK_HZ=1000 (DIV=4), LFSR_W=4, MIN_DELAY=2, NP=2: pulse start, hold react=0 -> WAIT, then GO exactly 4*delay_ticks cycles after WAIT entry, with led_on=1; delay_ticks matches the model LFSR value +2.
REQ-035 Same setup: in GO, assert react=2'b01 after 37 ticks -> DONE, time_bcd=0x0037, winner=01, best_bcd=0x0037; a second round at 25 ticks gives best_bcd=0x0025, and a third at 40 ticks leaves best_bcd=0x0025.
REQ-036 Same setup: assert react=2'b10 during WAIT -> FAULT, false_start=1, winner=10, led_on=0, best_bcd unchanged; then a start edge -> WAIT with flags cleared.
REQ-037 Same setup: assert react=2'b11 in the same GO cycle -> winner=11; with NDIG=2 and no react -> timeout=1 at time_bcd=0x99, winner=00.
REQ-038 Same setup: assert reset mid-GO -> all outputs at reset values within the same cycle; a start held high across reset release produces no transition until it falls and rises again.

Source files
------------

// File: rtl/reaction_timer_core.sv
// rtl/reaction_timer_core.sv - reaction timer: random delay, react lamp, BCD reaction time, best score
`timescale 1ns/1ps
module reaction_timer_core #(
  parameter int CLK_HZ    = 50000000,
  parameter int TICK_HZ   = 1000,
  parameter int LFSR_W    = 11,
  parameter int MIN_DELAY = 500,
  parameter int NDIG      = 4,
  parameter int NP        = 2
) (
  input  logic                MAX10_CLK1_50,
  input  logic                reset,
  input  logic                start,
  input  logic [NP-1:0]       react,
  output logic [2:0]          state,
  output logic                led_on,
  output logic [LFSR_W+9:0]   delay_ticks,
  output logic [4*NDIG-1:0]   time_bcd,
  output logic [4*NDIG-1:0]   best_bcd,
  output logic [NP-1:0]       winner,
  output logic                false_start,
  output logic                timeout
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW  = LFSR_W + 10;
  localparam int TW  = 4 * NDIG;
  localparam logic [TW-1:0] ALL9 = {NDIG{4'h9}};

  // Feedback tap masks (bit t-1 set for tap t) of maximal-length polynomials.
  function automatic logic [15:0] lfsr_taps(input int w);
    case (w)
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h000C;
    endcase
  endfunction

  localparam logic [15:0]       TAP16 = lfsr_taps(LFSR_W);
  localparam logic [LFSR_W-1:0] TAPS  = TAP16[LFSR_W-1:0];

  // Decimal increment: each digit wraps 9->0 and carries into the next.
  function automatic logic [TW-1:0] bcd_inc(input logic [TW-1:0] v);
    logic [TW-1:0] res;
    logic          carry;
    res   = v;
    carry = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          res[4*i +: 4] = 4'd0;
        end else begin
          res[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return res;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_WAIT  = 3'b001,
    S_GO    = 3'b010,
    S_DONE  = 3'b011,
    S_FAULT = 3'b100
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_start;
  logic              r_armed;
  logic [LFSR_W-1:0] r_lfsr;
  logic [PW-1:0]     r_presc;
  logic [DW-1:0]     r_delay;
  logic [DW-1:0]     r_remain;
  logic [TW-1:0]     r_time;
  logic [TW-1:0]     r_best;
  logic [NP-1:0]     r_winner;
  logic              r_false_start;
  logic              r_timeout;

  logic w_start_edge;
  logic w_any_react;
  logic w_tick;
  logic w_capture;
  logic w_go;
  logic w_dec;
  logic w_fault;
  logic w_win;
  logic w_timeout;
  logic w_inc;

  // r_armed blocks a start held high through reset release from counting as an edge.
  assign w_start_edge = start & ~r_start & r_armed;
  assign w_any_react  = |react;
  assign w_tick       = ((r_state == S_WAIT) || (r_state == S_GO)) && (r_presc == PW'(DIV - 1));

  // State register; unused encodings fall through to IDLE via the next-state default.
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and one-cycle datapath strobes; react outranks any tick-driven move.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_go      = 1'b0;
    w_dec     = 1'b0;
    w_fault   = 1'b0;
    w_win     = 1'b0;
    w_timeout = 1'b0;
    w_inc     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_FAULT: begin
        if (w_start_edge) begin
          w_next    = S_WAIT;
          w_capture = 1'b1;
        end
      end
      S_WAIT: begin
        if (w_any_react) begin
          w_next  = S_FAULT;
          w_fault = 1'b1;
        end else if (w_tick) begin
          if (r_remain <= DW'(1)) begin
            w_next = S_GO;
            w_go   = 1'b1;
          end else begin
            w_dec = 1'b1;
          end
        end
      end
      S_GO: begin
        if (w_any_react) begin
          w_next = S_DONE;
          w_win  = 1'b1;
        end else if (w_tick) begin
          if (r_time == ALL9) begin
            w_next    = S_DONE;
            w_timeout = 1'b1;
          end else begin
            w_inc = 1'b1;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Start sampling for edge detection, armed once start is seen low after reset.
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      r_start <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_start <= start;
      r_armed <= r_armed | ~start;
    end
  end

  // Free-running Fibonacci LFSR; seeded all ones so it never reaches zero.
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) r_lfsr <= '1;
    else       r_lfsr <= {r_lfsr[LFSR_W-2:0], ^(r_lfsr & TAPS)};
  end

  // Tick prescaler, restarted from zero on every entry to WAIT or GO.
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_capture || w_go) begin
      r_presc <= '0;
    end else if ((r_state == S_WAIT) || (r_state == S_GO)) begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end else begin
      r_presc <= '0;
    end
  end

  // Round datapath: delay capture, countdown, reaction counter, outcome flags, best score.
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      r_delay       <= '0;
      r_remain      <= '0;
      r_time        <= '0;
      r_best        <= ALL9;
      r_winner      <= '0;
      r_false_start <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      if (w_capture) begin
        r_delay       <= DW'(MIN_DELAY) + DW'(r_lfsr);
        r_remain      <= DW'(MIN_DELAY) + DW'(r_lfsr);
        r_time        <= '0;
        r_winner      <= '0;
        r_false_start <= 1'b0;
        r_timeout     <= 1'b0;
      end
      if (w_dec) r_remain <= r_remain - 1'b1;
      if (w_fault) begin
        r_false_start <= 1'b1;
        r_winner      <= react;
      end
      if (w_win) begin
        r_winner <= react;
        if (r_time < r_best) r_best <= r_time;
      end
      if (w_timeout) begin
        r_timeout <= 1'b1;
        r_winner  <= '0;
      end
      if (w_inc) r_time <= bcd_inc(r_time);
    end
  end

  assign state       = r_state;
  assign led_on      = (r_state == S_GO);
  assign delay_ticks = r_delay;
  assign time_bcd    = r_time;
  assign best_bcd    = r_best;
  assign winner      = r_winner;
  assign false_start = r_false_start;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_reaction_timer_core.sv
// tb/tb_reaction_timer_core.sv - randomized self-checking bench for reaction_timer_core
`timescale 1ns/1ps
module tb_reaction_timer_core;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        start  = 1'b0;
  logic        start2 = 1'b0;
  logic [1:0]  react  = 2'b00;
  logic [1:0]  react2 = 2'b00;
  logic [2:0]  state, state2;
  logic        led_on, led_on2, false_start, false_start2, timeout, timeout2;
  logic [13:0] delay_ticks, delay_ticks2;
  logic [15:0] time_bcd, best_bcd;
  logic [7:0]  time_bcd2, best_bcd2;
  logic [1:0]  winner, winner2;

  int n_tests  = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int best_int = 9999;

  always #5 clk = ~clk;

  // Clock edges since reset release: the LFSR has shifted exactly this many times.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  reaction_timer_core #(.CLK_HZ(4000), .TICK_HZ(1000), .LFSR_W(4), .MIN_DELAY(2), .NDIG(4), .NP(2)) dut (
    .MAX10_CLK1_50(clk), .reset(reset), .start(start), .react(react),
    .state(state), .led_on(led_on), .delay_ticks(delay_ticks), .time_bcd(time_bcd),
    .best_bcd(best_bcd), .winner(winner), .false_start(false_start), .timeout(timeout)
  );

  reaction_timer_core #(.CLK_HZ(4000), .TICK_HZ(1000), .LFSR_W(4), .MIN_DELAY(2), .NDIG(2), .NP(2)) dut2 (
    .MAX10_CLK1_50(clk), .reset(reset), .start(start2), .react(react2),
    .state(state2), .led_on(led_on2), .delay_ticks(delay_ticks2), .time_bcd(time_bcd2),
    .best_bcd(best_bcd2), .winner(winner2), .false_start(false_start2), .timeout(timeout2)
  );

  // x^4 + x^3 + 1 sequence starting from all ones, period 15.
  function automatic logic [3:0] lfsr_after(input int n);
    logic [3:0] q;
    q = 4'hF;
    for (int i = 0; i < (n % 15); i++) q = {q[2:0], q[3] ^ q[2]};
    return q;
  endfunction

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_round1(output int d);
    @(negedge clk);
    d = 2 + int'(lfsr_after(cyc));
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("wait_entry", 32'(state), 1);
    chk("delay_capture", 32'(delay_ticks), d);
    chk("time_cleared", 32'(time_bcd), 0);
    chk("winner_cleared", 32'(winner), 0);
    chk("flags_cleared", 32'({false_start, timeout}), 0);
    chk("led_wait", 32'(led_on), 0);
  endtask

  task automatic wait_go1(input int d, input int k0);
    int k;
    k = k0;
    while (state !== 3'd2 && k < 4*d + 20) begin
      @(negedge clk);
      k++;
    end
    chk("go_latency", k, 4*d);
    chk("go_led", 32'(led_on), 1);
  endtask

  task automatic do_round(input int n, input logic [1:0] pat, input bit extra);
    int d;
    int k0;
    repeat ($urandom_range(0, 20)) @(negedge clk);
    start_round1(d);
    k0 = 0;
    if (extra) begin
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      k0 = 2;
      chk("wait_restart_ignored", 32'(state), 1);
      chk("wait_delay_held", 32'(delay_ticks), d);
    end
    wait_go1(d, k0);
    repeat (4*n) @(posedge clk);
    @(negedge clk) react = pat;
    @(negedge clk) react = 2'b00;
    if (n < best_int) best_int = n;
    chk("done_state", 32'(state), 3);
    chk("done_time", 32'(time_bcd), to_bcd(n));
    chk("done_winner", 32'(winner), 32'(pat));
    chk("done_led", 32'(led_on), 0);
    chk("done_timeout", 32'(timeout), 0);
    chk("done_best", 32'(best_bcd), to_bcd(best_int));
    if (extra) begin
      @(negedge clk) react = 2'b11;
      @(negedge clk) react = 2'b00;
      repeat (6) @(negedge clk);
      chk("done_hold_state", 32'(state), 3);
      chk("done_hold_winner", 32'(winner), 32'(pat));
      chk("done_hold_time", 32'(time_bcd), to_bcd(n));
    end
  endtask

  task automatic do_fault(input logic [1:0] pat, input bit late);
    int d;
    int r;
    repeat ($urandom_range(0, 20)) @(negedge clk);
    start_round1(d);
    r = late ? 4*d - 1 : int'($urandom_range(0, 4*d - 2));
    repeat (r) @(negedge clk);
    react = pat;
    @(negedge clk) react = 2'b00;
    chk("fault_state", 32'(state), 4);
    chk("fault_flag", 32'(false_start), 1);
    chk("fault_winner", 32'(winner), 32'(pat));
    chk("fault_led", 32'(led_on), 0);
    chk("fault_timeout", 32'(timeout), 0);
    chk("fault_best", 32'(best_bcd), to_bcd(best_int));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d2;
    int k;
    int d;

    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state), 0);
    chk("rst_best", 32'(best_bcd), 32'h9999);
    chk("rst_delay", 32'(delay_ticks), 0);
    chk("rst_led", 32'(led_on), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_without_start", 32'(state), 0);

    do_round(37, 2'b01, 1'b1);
    do_round(25, 2'b01, 1'b0);
    do_round(40, 2'b01, 1'b0);
    do_fault(2'b10, 1'b0);
    do_round(30, 2'b11, 1'b0);
    do_fault(2'b01, 1'b1);

    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 3) == 0) do_fault(2'($urandom_range(1, 3)), 1'b0);
      else do_round(int'($urandom_range(1, 60)), 2'($urandom_range(1, 3)), 1'b0);
    end

    @(negedge clk);
    d2 = 2 + int'(lfsr_after(cyc));
    start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    chk("to_wait_entry", 32'(state2), 1);
    chk("to_delay", 32'(delay_ticks2), d2);
    k = 0;
    while (state2 !== 3'd2 && k < 4*d2 + 20) begin
      @(negedge clk);
      k++;
    end
    chk("to_go_latency", k, 4*d2);
    k = 0;
    while (state2 !== 3'd3 && k < 420) begin
      @(negedge clk);
      k++;
    end
    chk("to_latency", k, 400);
    chk("to_flag", 32'(timeout2), 1);
    chk("to_time", 32'(time_bcd2), 32'h99);
    chk("to_winner", 32'(winner2), 0);
    chk("to_best", 32'(best_bcd2), 32'h99);
    chk("to_led", 32'(led_on2), 0);
    chk("to_false_start", 32'(false_start2), 0);

    start_round1(d);
    wait_go1(d, 0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    best_int = 9999;
    chk("rst_go_state", 32'(state), 0);
    chk("rst_go_led", 32'(led_on), 0);
    chk("rst_go_delay", 32'(delay_ticks), 0);
    chk("rst_go_time", 32'(time_bcd), 0);
    chk("rst_go_winner", 32'(winner), 0);
    chk("rst_go_flags", 32'({false_start, timeout}), 0);
    chk("rst_go_best", 32'(best_bcd), 32'h9999);
    start = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("held_start_no_edge", 32'(state), 0);
    start = 1'b0;
    @(negedge clk);
    start_round1(d);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
